// File: rtl/string_sender.sv
// ============================================================================
//  Module   : string_sender
//  Purpose  : Streams a null-terminated string from a 1-cycle-latency ROM into
//             a FIFO write port, one byte per clock, with backpressure and a
//             length limit for strings that are missing their terminator.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module string_sender #(
    parameter int AW     = 4,
    parameter int MAXLEN = 16,
    parameter int LW     = $clog2(MAXLEN + 1)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          start_i,
    input  logic [AW-1:0] addr_i,
    input  logic          full_i,
    output logic [AW-1:0] mem_addr_o,
    input  logic [7:0]    mem_data_i,
    output logic [7:0]    byte_o,
    output logic          wren_o,
    output logic          busy_o,
    output logic          done_o,
    output logic          overrun_o,
    output logic [LW-1:0] count_o
);

    localparam logic [LW-1:0] C_MAXLEN = LW'(MAXLEN);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_SEND  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic [AW-1:0] r_ptr;
    logic [LW-1:0] r_cnt;
    logic          r_overrun;
    logic          r_done;
    logic          w_null;
    logic          w_limit;
    logic          w_accept;

    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        w_null   = (mem_data_i == 8'h00);
        w_limit  = (r_cnt == C_MAXLEN);
        case (r_state)
            ST_IDLE:  if (start_i) w_next = ST_FETCH;
            ST_FETCH: w_next = ST_SEND;
            ST_SEND: begin
                // Terminator beats the length limit, which beats backpressure.
                if (w_null || w_limit) begin
                    w_next = ST_DONE;
                end else if (!full_i) begin
                    w_accept = 1'b1;
                end
            end
            ST_DONE:  w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    // Look one address ahead on an accept so the ROM keeps pace at 1 byte/clk.
    assign mem_addr_o = w_accept ? (r_ptr + AW'(1)) : r_ptr;
    assign wren_o     = w_accept;
    assign byte_o     = mem_data_i;
    assign busy_o     = (r_state != ST_IDLE);
    assign done_o     = r_done;
    assign overrun_o  = r_overrun;
    assign count_o    = r_cnt;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state   <= ST_IDLE;
            r_ptr     <= '0;
            r_cnt     <= '0;
            r_overrun <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state <= w_next;
            r_done  <= (w_next == ST_DONE);
            if (r_state == ST_IDLE && start_i) begin
                r_ptr     <= addr_i;
                r_cnt     <= '0;
                r_overrun <= 1'b0;
            end
            if (r_state == ST_SEND && !w_null && w_limit) begin
                r_overrun <= 1'b1;
            end
            if (w_accept) begin
                r_ptr <= r_ptr + AW'(1);
                r_cnt <= r_cnt + LW'(1);
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_string_sender.sv
// ============================================================================
//  Module   : tb_string_sender
//  Purpose  : Self-checking bench for string_sender: directed scenarios plus
//             randomized strings/backpressure against an index-based model.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_string_sender;

    localparam int AW     = 4;
    localparam int MAXLEN = 16;
    localparam int LW     = $clog2(MAXLEN + 1);
    localparam int DEPTH  = 1 << AW;

    logic          clk   = 1'b0;
    logic          rst   = 1'b1;
    logic          start = 1'b0;
    logic          full  = 1'b0;
    logic [AW-1:0] addr  = '0;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_data;
    logic [7:0]    byte_w;
    logic          wren, busy, done, overrun;
    logic [LW-1:0] count;

    logic [7:0] rom [DEPTH];

    int n_checks = 0;
    int n_errors = 0;

    string_sender #(.AW(AW), .MAXLEN(MAXLEN)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .start_i    (start),
        .addr_i     (addr),
        .full_i     (full),
        .mem_addr_o (mem_addr),
        .mem_data_i (mem_data),
        .byte_o     (byte_w),
        .wren_o     (wren),
        .busy_o     (busy),
        .done_o     (done),
        .overrun_o  (overrun),
        .count_o    (count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) mem_data <= rom[mem_addr];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Model: the string is base..base+pos; phase 0 idle, 1 rom wait, 2 send, 3 done.
    int m_phase = 0;
    int m_base  = 0;
    int m_pos   = 0;
    bit m_ovr   = 1'b0;
    bit m_valid = 1'b0;

    function automatic logic [AW-1:0] idx(input int k);
        return AW'((m_base + k) % DEPTH);
    endfunction

    function automatic logic [7:0] m_cur();
        return rom[idx(m_pos)];
    endfunction

    function automatic bit m_wren();
        return (m_phase == 2) && (m_cur() != 8'h00) && (m_pos < MAXLEN) && !full;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_phase = 0; m_base = 0; m_pos = 0; m_ovr = 1'b0; m_valid = 1'b1;
        end else begin
            case (m_phase)
                0: if (start) begin
                       m_base = int'(addr); m_pos = 0; m_ovr = 1'b0; m_phase = 1;
                   end
                1: m_phase = 2;
                2: if (m_cur() == 8'h00) m_phase = 3;
                   else if (m_pos == MAXLEN) begin m_ovr = 1'b1; m_phase = 3; end
                   else if (!full) m_pos++;
                default: m_phase = 0;
            endcase
        end
    end

    always @(negedge clk) begin
        logic       ew;
        logic [7:0] eb;
        if (m_valid) begin
            ew = m_wren();
            eb = m_cur();
            check("busy", 32'(busy), 32'(m_phase != 0));
            check("wren", 32'(wren), 32'(ew));
            check("done", 32'(done), 32'(m_phase == 3));
            check("overrun", 32'(overrun), 32'(m_ovr));
            check("count", 32'(count), 32'(m_pos));
            check("mem_addr", 32'(mem_addr), 32'(idx(m_pos + (ew ? 1 : 0))));
            if (ew) check("byte", 32'(byte_w), 32'(eb));
        end
    end

    // Per-run observations for directed scenarios
    logic [7:0]    got[$];
    logic [AW-1:0] addrs[$];
    int busy_n, done_at, first_wr;

    task automatic run_string(input int a, input int full_from, input int full_len,
                              input int rst_at, input int start_at);
        bit finished;
        finished = 1'b0;
        got.delete(); addrs.delete();
        busy_n = 0; done_at = -1; first_wr = -1;
        addr  = AW'(a);
        start = 1'b1;
        step();
        start = 1'b0;
        for (int cyc = 1; cyc < 100; cyc++) begin
            full  = (cyc >= full_from) && (cyc < full_from + full_len);
            rst   = (cyc == rst_at);
            start = (cyc == start_at);
            if (start) addr = AW'(a + 7);
            @(negedge clk);
            if (busy) busy_n++;
            if (wren) begin
                got.push_back(byte_w);
                if (first_wr < 0) first_wr = cyc;
            end
            if (cyc == 1 || wren) addrs.push_back(mem_addr);
            if (done) done_at = cyc;
            if (!busy) begin
                finished = 1'b1;
                break;
            end
            step();
        end
        full = 1'b0; rst = 1'b0; start = 1'b0;
        check("run_terminates", 32'(finished), 32'd1);
    endtask

    task automatic load_hello();
        for (int i = 0; i < DEPTH; i++) rom[i] = 8'h00;
        rom[3] = 8'h48; rom[4] = 8'h45; rom[5] = 8'h4C;
        rom[6] = 8'h4C; rom[7] = 8'h4F; rom[8] = 8'h00;
    endtask

    task automatic check_hello(input string tag);
        logic [7:0] exp [5];
        exp = '{8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F};
        check({tag, "_nbytes"}, 32'(got.size()), 32'd5);
        for (int i = 0; i < 5 && i < got.size(); i++)
            check({tag, "_byte"}, 32'(got[i]), 32'(exp[i]));
    endtask

    initial begin
        load_hello();
        rst = 1'b1;
        step(); step();
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_wren", 32'(wren), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        step();
        rst = 1'b0;
        step();

        // Basic "HELLO"
        run_string(3, 0, 0, -1, -1);
        check_hello("basic");
        check("basic_first_wr", 32'(first_wr), 32'd2);
        check("basic_busy", 32'(busy_n), 32'd8);
        check("basic_done_at", 32'(done_at), 32'd8);
        check("basic_count", 32'(count), 32'd5);
        check("basic_model_pos", 32'(m_pos), 32'd5);
        check("basic_overrun", 32'(overrun), 32'd0);

        // full_i held for 3 cycles over the 2nd byte
        run_string(3, 3, 3, -1, -1);
        check_hello("bp");
        check("bp_busy", 32'(busy_n), 32'd11);
        check("bp_done_at", 32'(done_at), 32'd11);

        // Empty string
        rom[0] = 8'h00;
        run_string(0, 0, 0, -1, -1);
        check("empty_nbytes", 32'(got.size()), 32'd0);
        check("empty_done_at", 32'(done_at), 32'd3);
        check("empty_count", 32'(count), 32'd0);

        // No terminator anywhere: limited to MAXLEN writes
        for (int i = 0; i < DEPTH; i++) rom[i] = 8'h41;
        run_string(5, 0, 0, -1, -1);
        check("ovr_nbytes", 32'(got.size()), 32'(MAXLEN));
        check("ovr_done_at", 32'(done_at), 32'(MAXLEN + 3));
        check("ovr_flag", 32'(overrun), 32'd1);
        check("ovr_count", 32'(count), 32'(MAXLEN));

        // Address wrap from 15 to 0
        for (int i = 0; i < DEPTH; i++) rom[i] = 8'h00;
        rom[15] = 8'h41; rom[0] = 8'h42; rom[1] = 8'h00;
        run_string(15, 0, 0, -1, -1);
        check("wrap_naddr", 32'(addrs.size()), 32'd3);
        if (addrs.size() == 3) begin
            check("wrap_addr0", 32'(addrs[0]), 32'd15);
            check("wrap_addr1", 32'(addrs[1]), 32'd0);
            check("wrap_addr2", 32'(addrs[2]), 32'd1);
        end
        check("wrap_nbytes", 32'(got.size()), 32'd2);
        if (got.size() == 2) begin
            check("wrap_byte0", 32'(got[0]), 32'h41);
            check("wrap_byte1", 32'(got[1]), 32'h42);
        end
        check("wrap_done_at", 32'(done_at), 32'd5);

        // Reset during the 3rd byte, ignored start while busy, then a clean run
        load_hello();
        run_string(3, 0, 0, 4, -1);
        check("rst_mid_nbytes", 32'(got.size()), 32'd3);
        check("rst_mid_busy", 32'(busy_n), 32'd4);
        check("rst_mid_no_done", 32'(done_at), 32'hFFFF_FFFF);
        check("rst_mid_count", 32'(count), 32'd0);
        run_string(3, 0, 0, -1, 3);
        check_hello("ignored_start");
        check("ignored_start_busy", 32'(busy_n), 32'd8);
        run_string(3, 0, 0, -1, -1);
        check_hello("after_reset");

        // Randomized strings, backpressure, stray starts and occasional resets
        for (int it = 0; it < 150; it++) begin
            int guard;
            for (int i = 0; i < DEPTH; i++) begin
                if (it % 10 == 0) rom[i] = 8'($urandom_range(1, 255));
                else rom[i] = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
            end
            repeat ($urandom_range(0, 3)) step();
            addr  = AW'($urandom);
            start = 1'b1;
            step();
            start = 1'b0;
            guard = 0;
            while (m_phase != 0 && guard < 200) begin
                full  = ($urandom_range(0, 3) == 0);
                start = ($urandom_range(0, 9) == 0);
                addr  = AW'($urandom);
                rst   = ($urandom_range(0, 60) == 0);
                step();
                guard++;
            end
            rst = 1'b0; full = 1'b0; start = 1'b0;
            check("rand_terminates", 32'(guard < 200), 32'd1);
        end
        step(); step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/string_sender.md
# string_sender

Upstream feeder for the UART FIFO. On a start pulse it streams a null-terminated string out of a synchronous 1-cycle-latency ROM into the FIFO write port, one byte per clock. It honours the FIFO `full` backpressure, stops at the terminating 0x00, which is never written, and guards against missing terminators with a length limit. It replaces the ad-hoc countdown/rden/wren logic in the top level.

## Interface

Parameters:

- `AW`, 4: ROM address width; the address pointer wraps modulo 2^AW.
- `MAXLEN`, 16: maximum bytes written per string; must be between 1 and 255.
- `LW`, `$clog2(MAXLEN+1)`: width of `count_o`.

Ports:

- `clk_i` input, 1: single clock, used for everything.
- `rst_i` input, 1: reset, synchronous and active-high.
- `start_i` input, 1: start request; only sampled in IDLE.
- `addr_i` input, AW: first ROM address of the string; captured with `start_i`.
- `full_i` input, 1: FIFO full.
- `mem_addr_o` output, AW: ROM address; combinational.
- `mem_data_i` input, 8: ROM data for the address presented on the previous cycle.
- `byte_o` output, 8: FIFO write data; equals `mem_data_i`.
- `wren_o` output, 1: FIFO write strobe; combinational; one byte per high cycle.
- `busy_o` output, 1: high whenever the state is not IDLE.
- `done_o` output, 1: one-cycle registered pulse after the string ends.
- `overrun_o` output, 1: registered; set with `done_o` when MAXLEN was reached without seeing 0x00; held until the next start.
- `count_o` output, LW: registered; bytes written for the last/current string; held until the next start.

## Operation

- **Registered state:** `state` (IDLE, FETCH, SEND, DONE), `ptr[AW-1:0]`, `cnt[LW-1:0]` (drives `count_o`), `overrun_o`, `done_o`.
- **IDLE:**
  - On `start_i`: `ptr <= addr_i`, `cnt <= 0`, `overrun_o <= 0`, next state FETCH.
  - Otherwise stay in IDLE.
- **FETCH:** `mem_addr_o = ptr`; next state SEND unconditionally. This cycle exists only to cover the ROM latency.
- **SEND:** `mem_data_i` holds ROM[ptr]. Evaluate in priority order:
  1. `mem_data_i == 0` → DONE. No write.
  2. `cnt == MAXLEN` → `overrun_o <= 1`, DONE. No write.
  3. `full_i` → stay in SEND. No write. `ptr` is held, and `mem_addr_o = ptr` re-reads the same byte.
  4. Otherwise `wren_o = 1`, `ptr <= ptr+1` (wraps), `cnt <= cnt+1`, stay in SEND.
- **Address output in SEND:** `mem_addr_o = ptr+1` on an accept cycle (case 4), else `ptr`. This gives 1 byte/clk throughput. The combinational path from `full_i` to `mem_addr_o` is intentional.
- **DONE:** `done_o <= 1` for exactly one cycle; next state IDLE.
- **`wren_o`:** high only in SEND case 4; 0 in every other state.
- **`byte_o`:** always equals `mem_data_i`; its value matters only while `wren_o` is high.
- **`start_i` outside IDLE:** ignored, with no queueing.
- **Reset:** `rst_i` has priority over all inputs.
  - Values after reset: `state` = IDLE, `ptr` = 0, `cnt` = 0, `overrun_o` = 0, `done_o` = 0.
  - Consequently `busy_o` = 0, `wren_o` = 0, `mem_addr_o` = 0.
  - Reset mid-string aborts it: no further writes and no `done_o`.
- **Width rules:** `cnt` saturates at MAXLEN by construction (case 2 fires before any increment). `ptr` wraps from 2^AW−1 to 0 without any special handling.

## Timing

- `start_i` is sampled at edge E0. Cycle after E0 is FETCH; the cycle after that is the first SEND.
- First possible `wren_o` is 2 cycles after the start edge.
- A string of n non-null bytes with no backpressure:
  - `wren_o` is high for n consecutive cycles.
  - The terminating SEND cycle, where data is 0x00, follows immediately.
  - `done_o` is high in the next cycle (DONE).
  - `busy_o` drops the cycle after that.
  - Total busy cycles: n+3.
- Each cycle with `full_i` high in SEND adds exactly one cycle and no duplicate write.
- `count_o` updates at the edge ending each write cycle. It is final when `done_o` is high.
- A new `start_i` can be accepted in the first IDLE cycle after DONE.

## Test plan

- **Basic string:** ROM[3..8] = 48 45 4C 4C 4F 00; `start_i` with `addr_i`=3, `full_i`=0 → `wren_o` high on 5 consecutive cycles starting 2 cycles after start, `byte_o` = 48,45,4C,4C,4F; `done_o` 1 cycle later; `count_o`=5; `overrun_o`=0.
- **Backpressure:** same string; `full_i` high for 3 cycles during the 2nd byte → 0x45 written exactly once after `full_i` drops; total busy 5+3+3 = 11 cycles; no byte lost or duplicated.
- **Empty string:** ROM[0]=00, start at 0 → no `wren_o`; `done_o` 3 cycles after start; `count_o`=0.
- **Overrun:** MAXLEN=4, ROM all 0x41 → exactly 4 writes; `overrun_o`=1 with `done_o`; `count_o`=4.
- **Wrap-around:** AW=4, string "AB" at address 15 with ROM[15]=41, ROM[0]=42, ROM[1]=00 → `mem_addr_o` sequence 15,0,1; bytes 41,42 written; `done_o` asserted.
- **Reset and retrigger:** `rst_i` pulse during the 3rd byte → `wren_o` is 0 from the next cycle, `busy_o`=0, no `done_o`. `start_i` pulses while `busy_o` is high → ignored. Start after reset → full string sent correctly.
